// File: rtl/if_stage_prefetch_pkg.sv
// Shared types and helpers for the prefetching fetch stage (package if_pkg).
// Entry fields are XLEN wide; instantiate the stage with BIT_NUMBER == XLEN.
package if_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned XLEN       = 32;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] addr;
   } fetch_entry_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 0;
      while ((32'd1 << w) < value) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/if_stage_prefetch_if.sv
// Instruction-memory handshake plus decode-side outputs of the fetch stage.
interface if_stage_prefetch_if #(
   parameter int unsigned BIT_NUMBER = 32
);
   logic                  imem_req;
   logic [BIT_NUMBER-1:0] imem_addr;
   logic                  imem_ack;
   logic [BIT_NUMBER-1:0] imem_rdata;
   logic                  instr_valid;
   logic [BIT_NUMBER-1:0] instruction;
   logic [BIT_NUMBER-1:0] pc;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output instr_valid, instruction, pc
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  instr_valid, instruction, pc
   );
endinterface

// File: rtl/if_stage_prefetch_fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; pointers wrap naturally.
module fetch_fifo
   import if_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  fetch_entry_t             i_entry,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [clog2(DEPTH):0]    o_count,
   output fetch_entry_t             o_head
);
   localparam int unsigned PTR_W = clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;

   assign w_pop   = i_pop && (r_count != '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_entry;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/if_stage_prefetch.sv
// Prefetching fetch stage: credit-limited sequential fetch into a queue feeding decode.
// Optional macro IF_PERF_CNT_EN adds saturating fetch_count / flush_count outputs.
module if_stage_prefetch
   import if_pkg::*;
#(
   parameter int unsigned           BIT_NUMBER = 32,
   parameter int unsigned           FIFO_DEPTH = 4,
   parameter logic [BIT_NUMBER-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  freeze,
   input  logic                  branch_taken,
   input  logic [BIT_NUMBER-1:0] branch_address,
   if_stage_prefetch_if.master   bus
`ifdef IF_PERF_CNT_EN
   ,
   output logic [BIT_NUMBER-1:0] fetch_count,
   output logic [BIT_NUMBER-1:0] flush_count
`endif
);
   localparam int unsigned PTR_W = clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned INF_W = CNT_W + 1;

   logic [BIT_NUMBER-1:0] r_fetch_pc;
   logic [BIT_NUMBER-1:0] r_pending_addr;
   logic                  r_pending;

   logic [CNT_W-1:0]      w_count;
   logic [INF_W-1:0]      w_inflight;
   fetch_entry_t          w_head;
   fetch_entry_t          w_push_entry;
   logic                  w_req;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_valid;

   // Queued entries plus the outstanding response must fit, so a push never overflows.
   assign w_inflight = {1'b0, w_count} + INF_W'(r_pending);
   assign w_req      = (w_inflight < INF_W'(FIFO_DEPTH)) && !branch_taken && !rst;
   assign w_accept   = w_req && bus.imem_ack;
   assign w_valid    = (w_count != '0);
   assign w_push     = r_pending && !branch_taken;
   assign w_pop      = w_valid && !freeze && !branch_taken;

   always_comb begin
      w_push_entry       = '0;
      w_push_entry.instr = bus.imem_rdata;
      w_push_entry.addr  = r_pending_addr;
   end

   assign bus.imem_req    = w_req;
   assign bus.imem_addr   = r_fetch_pc;
   assign bus.instr_valid = w_valid;
   assign bus.instruction = w_valid ? w_head.instr : '0;
   assign bus.pc          = w_valid ? (w_head.addr + BIT_NUMBER'(WORD_BYTES)) : '0;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_entry (w_push_entry),
      .i_pop   (w_pop),
      .i_flush (branch_taken),
      .o_count (w_count),
      .o_head  (w_head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc     <= RESET_PC;
         r_pending      <= 1'b0;
         r_pending_addr <= '0;
      end else if (branch_taken) begin
         r_fetch_pc <= branch_address;
         r_pending  <= 1'b0;
      end else begin
         r_pending <= w_accept;
         if (w_accept) begin
            r_pending_addr <= r_fetch_pc;
            r_fetch_pc     <= r_fetch_pc + BIT_NUMBER'(WORD_BYTES);
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= '0;
         flush_count <= '0;
      end else begin
         if (w_accept && (fetch_count != '1))
            fetch_count <= fetch_count + BIT_NUMBER'(1);
         if (branch_taken && (w_valid || r_pending) && (flush_count != '1))
            flush_count <= flush_count + BIT_NUMBER'(1);
      end
   end
`endif
endmodule

// File: tb/tb_if_stage_prefetch.sv
// Directed and random stimulus for if_stage_prefetch against a queue-based reference model.
module tb_if_stage_prefetch;
   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0;
   localparam logic [31:0] TAG    = 32'hE000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_address = '0;

   if_stage_prefetch_if #(.BIT_NUMBER(32)) bus ();

   if_stage_prefetch #(
      .BIT_NUMBER (32),
      .FIFO_DEPTH (DEPTH),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .freeze         (freeze),
      .branch_taken   (branch_taken),
      .branch_address (branch_address),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t        mq[$];
   logic [31:0] m_pc = RST_PC;
   logic [31:0] m_pend_addr = '0;
   bit          m_pend = 1'b0;
   bit          resp_valid = 1'b0;
   logic [31:0] resp_addr = '0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_acc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check at negedge+1, advance the model at posedge.
   task automatic step(input bit frz, input bit br, input logic [31:0] ba, input bit ack);
      bit          exp_req;
      bit          hs;
      logic [31:0] hs_addr;
      exp_t        e;
      @(negedge clk);
      freeze         = frz;
      branch_taken   = br;
      branch_address = ba;
      bus.imem_ack   = ack;
      bus.imem_rdata = resp_valid ? (resp_addr | TAG) : $urandom;
      #1;
      exp_req = ((mq.size() + (m_pend ? 1 : 0)) < DEPTH) && !br;
      chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
      chk("instr_valid", 32'(bus.instr_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("instruction", bus.instruction, mq[0].instr);
         chk("pc", bus.pc, mq[0].pc);
      end
      hs      = bus.imem_req && ack;
      hs_addr = bus.imem_addr;
      if (hs) n_acc++;
      @(posedge clk);
      if (br) begin
         mq.delete();
         m_pend = 1'b0;
         m_pc   = ba;
      end else begin
         if (mq.size() != 0 && !frz) void'(mq.pop_front());
         if (m_pend) begin
            e.instr = m_pend_addr | TAG;
            e.pc    = m_pend_addr + 32'd4;
            mq.push_back(e);
         end
         m_pend = exp_req && ack;
         if (m_pend) begin
            m_pend_addr = m_pc;
            m_pc        = m_pc + 32'd4;
         end
      end
      resp_valid = hs;
      resp_addr  = hs_addr;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instruction", bus.instruction, 32'd0);
      chk("rst_pc", bus.pc, 32'd0);
      mq.delete();
      m_pend     = 1'b0;
      m_pc       = RST_PC;
      resp_valid = 1'b0;
      freeze       = 1'b0;
      branch_taken = 1'b0;
      bus.imem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;

      // Streaming fetch after reset.
      do_reset();
      for (int i = 0; i < 12; i++) step(0, 0, '0, 1);

      // Freeze fills the queue, then drains in order.
      do_reset();
      n_acc = 0;
      for (int i = 0; i < 10; i++) step(1, 0, '0, 1);
      chk("freeze_accepts", 32'(n_acc), 32'd4);
      for (int i = 0; i < 6; i++) step(0, 0, '0, 0);

      // Redirect with three entries queued.
      do_reset();
      for (int i = 0; i < 20 && mq.size() < 3; i++) step(1, 0, '0, 1);
      step(1, 1, 32'h100, 1);
      for (int i = 0; i < 8; i++) step(0, 0, '0, 1);

      // Redirect in the same cycle as the response for 0x20.
      do_reset();
      for (int i = 0; i < 40 && m_pc != 32'h20; i++) step(0, 0, '0, 1);
      step(0, 0, '0, 1);
      step(0, 1, 32'h200, 1);
      for (int i = 0; i < 6; i++) step(0, 0, '0, 1);

      // Memory stall with an empty queue.
      step(0, 1, 32'h300, 1);
      for (int i = 0; i < 5; i++) step(0, 0, '0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

      // Address wrap at the top of the space.
      step(0, 1, 32'hFFFF_FFF8, 1);
      for (int i = 0; i < 6; i++) step(0, 0, '0, 1);

      // Asynchronous reset with two queued and one pending.
      do_reset();
      for (int i = 0; i < 20 && !(mq.size() == 2 && m_pend); i++) step(1, 0, '0, 1);
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         bit          frz;
         bit          br;
         bit          ack;
         logic [31:0] ba;
         frz = ($urandom_range(0, 99) < 30);
         br  = ($urandom_range(0, 99) < 10);
         ack = ($urandom_range(0, 99) < 70);
         ba  = $urandom & 32'hFFFF_FFFC;
         step(frz, br, ba, ack);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/if_stage_prefetch.md
Name: if_stage_prefetch

Overview:
- Next-generation ARM fetch stage: decouples the PC/instruction-memory path from decode through a parametrised prefetch queue.
- Issues sequential word fetches to an external instruction memory using a request/accept handshake with a fixed 1-cycle read latency.
- Buffers returned words with their PCs and presents them to the IF/ID register.
- Branch redirect flushes the queue and any in-flight fetch.

Parameters:
- BIT_NUMBER, 32, data/address width.
- FIFO_DEPTH, 4, prefetch queue entries (power of two, ≥2).
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  decode stall; holds the queue head.
- branch_taken  in  1  redirect request from the execute stage.
- branch_address  in  BIT_NUMBER  redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  BIT_NUMBER  fetch word address.
- imem_ack  in  1  memory accepts the request this cycle.
- imem_rdata  in  BIT_NUMBER  read data, valid exactly 1 cycle after an accepted request.
- instr_valid  out  1  queue head valid.
- instruction  out  BIT_NUMBER  queue head instruction.
- pc  out  BIT_NUMBER  queue head fetch address + 4.

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC; queue empty.
  - imem_req=0, instr_valid=0, instruction=0, pc=0.
  - Pending flag cleared.
- Issue:
  - imem_req=1 when count + pending < FIFO_DEPTH, branch_taken=0 and rst=0.
  - imem_addr=fetch_pc.
  - On imem_req & imem_ack: pending<=1; fetch_pc<=fetch_pc+4 (mod 2^BIT_NUMBER, wraps silently).
- Response: the cycle after acceptance, imem_rdata is pushed with its address. The credit rule guarantees the push never hits a full queue.
- Output:
  - instr_valid = count≠0. instruction and pc are combinational from the head.
  - pc = entry address + 4, matching the existing PC+4 convention.
- Dequeue: instr_valid & ~freeze & ~branch_taken pops the head.
- Simultaneous push and pop: count unchanged; a push into an empty queue appears on instr_valid the next cycle (fetch-to-decode latency 2 cycles minimum).
- Redirect (branch_taken=1), highest priority:
  - Same cycle: imem_req forced 0; no pop.
  - Clock edge: count<=0, pending<=0, fetch_pc<=branch_address.
  - Any response arriving that cycle is discarded.
  - Next cycle: requests resume from branch_address.
- Freeze:
  - Head held stable; fetches continue until the queue is full, then imem_req drops.
  - freeze together with branch_taken: the redirect still flushes.
- Memory stall: imem_ack=0 holds imem_addr and imem_req stable; nothing is pushed.
- Queue pointers: log2(FIFO_DEPTH) bits, wrap naturally; count is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_count and flush_count, each BIT_NUMBER wide, reset to 0, saturating at all-ones.
  - fetch_count increments per accepted request.
  - flush_count increments per cycle with branch_taken=1 that discards at least one queued entry or the pending response.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package if_pkg:
  - Constant WORD_BYTES=4.
  - Struct typedef fetch_entry_t {instr, addr}.
  - Function clog2 helper for pointer width.
- Sub-module fetch_fifo:
  - Parametrised sync FIFO of fetch_entry_t with push, pop, flush, count, head.
  - Uses the same async active-high reset.

Test Plan:
- Reset, then imem_ack=1, memory returns addr|0xE000_0000, freeze=0 → imem_addr 0,4,8,…; first instr_valid at cycle 2 with instruction 0xE000_0000, pc=4; then one instruction per cycle.
- freeze=1 held 10 cycles, FIFO_DEPTH=4 → exactly 4 requests accepted, imem_req then 0; head stays pc=4; releasing freeze drains pc 4,8,12,16 in order.
- Queue holding 3 entries, branch_taken=1 with branch_address=0x100 → next cycle instr_valid=0; next imem_addr=0x100; first valid output pc=0x104; no stale entry ever appears.
- branch_taken in the same cycle as a returning response for address 0x20 → that data is never output; the next accepted address is branch_address.
- imem_ack=0 for 5 cycles with the queue empty → imem_req=1 with imem_addr held; instr_valid=0; no push.
- Assert rst mid-stream with 2 entries queued and one pending → all outputs 0 immediately (asynchronously); after release, first imem_addr=RESET_PC.
